// File: rtl/multi_alarm_pkg.sv
// Shared definitions for the multi-slot alarm controller: slot state encoding,
// BCD digit limits and the digit range check.
package multi_alarm_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 2'd0,
        S_RING   = 2'd1,
        S_SNOOZE = 2'd2
    } slot_state_t;

    localparam logic [3:0] TENS_MAX = 4'd5;
    localparam logic [3:0] ONES_MAX = 4'd9;

    function automatic logic digit_ok(input logic is_tens, input logic [3:0] value);
        return is_tens ? (value <= TENS_MAX) : (value <= ONES_MAX);
    endfunction

endpackage

// File: rtl/multi_alarm_ctrl_slot.sv
// One alarm slot: stored MM:SS digits, enable bit and the ring/snooze/auto-silence
// state machine with its one-second countdown.
module alarm_slot
    import multi_alarm_pkg::*;
#(
    parameter int RING_SEC   = 30,
    parameter int SNOOZE_SEC = 60,
    parameter int CNT_W      = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_mtens,
    input  logic        ld_mones,
    input  logic        ld_stens,
    input  logic        ld_sones,
    input  logic [3:0]  ld_num,
    input  logic        ena_set,
    input  logic        ena_clr,
    input  logic        match,
    input  logic        tick,
    input  logic        snooze,
    input  logic        dismiss,
    output logic [3:0]  mtens,
    output logic [3:0]  mones,
    output logic [3:0]  stens,
    output logic [3:0]  sones,
    output logic        ena,
    output slot_state_t state
);

    localparam logic [CNT_W-1:0] RING_LD   = CNT_W'(RING_SEC);
    localparam logic [CNT_W-1:0] SNOOZE_LD = CNT_W'(SNOOZE_SEC);

    logic [3:0]       mtens_reg, mones_reg, stens_reg, sones_reg;
    logic             ena_reg;
    slot_state_t      state_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic mtens_ok, mones_ok, stens_ok, sones_ok, any_load;

    assign mtens_ok = ld_mtens && digit_ok(1'b1, ld_num);
    assign mones_ok = ld_mones && digit_ok(1'b0, ld_num);
    assign stens_ok = ld_stens && digit_ok(1'b1, ld_num);
    assign sones_ok = ld_sones && digit_ok(1'b0, ld_num);
    assign any_load = mtens_ok || mones_ok || stens_ok || sones_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            mtens_reg <= '0;
            mones_reg <= '0;
            stens_reg <= '0;
            sones_reg <= '0;
            ena_reg   <= 1'b0;
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
        end else begin
            if (mtens_ok) mtens_reg <= ld_num;
            if (mones_ok) mones_reg <= ld_num;
            if (stens_ok) stens_reg <= ld_num;
            if (sones_ok) sones_reg <= ld_num;

            if (ena_clr)      ena_reg <= 1'b0;
            else if (ena_set) ena_reg <= 1'b1;

            // Editing or disabling the slot, or a dismiss, always returns it to quiet.
            if (any_load || ena_clr || dismiss) begin
                state_reg <= S_IDLE;
                cnt_reg   <= '0;
            end else if (snooze && state_reg == S_RING) begin
                state_reg <= S_SNOOZE;
                cnt_reg   <= SNOOZE_LD;
            end else if (tick) begin
                case (state_reg)
                    S_IDLE: begin
                        if (ena_reg && match) begin
                            state_reg <= S_RING;
                            cnt_reg   <= RING_LD;
                        end
                    end
                    S_RING: begin
                        if (cnt_reg <= 1) begin
                            state_reg <= S_IDLE;
                            cnt_reg   <= '0;
                        end else begin
                            cnt_reg <= cnt_reg - 1'b1;
                        end
                    end
                    S_SNOOZE: begin
                        if (cnt_reg <= 1) begin
                            state_reg <= S_RING;
                            cnt_reg   <= RING_LD;
                        end else begin
                            cnt_reg <= cnt_reg - 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= S_IDLE;
                        cnt_reg   <= '0;
                    end
                endcase
            end
        end
    end

    assign mtens = mtens_reg;
    assign mones = mones_reg;
    assign stens = stens_reg;
    assign sones = sones_reg;
    assign ena   = ena_reg;
    assign state = state_reg;

endmodule

// File: rtl/multi_alarm_ctrl.sv
// N-slot alarm controller for the MM:SS clock: slot array, delayed one-second tick,
// ld_sel decode, selected-slot read mux and lowest-index ringing encoder.
module multi_alarm_ctrl
    import multi_alarm_pkg::*;
#(
    parameter int NUM_ALARMS = 4,
    parameter int IDX_W      = 2,
    parameter int RING_SEC   = 30,
    parameter int SNOOZE_SEC = 60,
    parameter int CNT_W      = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_oneSecStrb,
    input  logic [3:0]            cur_Mtens,
    input  logic [3:0]            cur_Mones,
    input  logic [3:0]            cur_Stens,
    input  logic [3:0]            cur_Sones,
    input  logic [IDX_W-1:0]      ld_sel,
    input  logic                  ld_Mtens,
    input  logic                  ld_Mones,
    input  logic                  ld_Stens,
    input  logic                  ld_Sones,
    input  logic [3:0]            ld_num,
    input  logic                  ena_set,
    input  logic                  ena_clr,
    input  logic                  snooze,
    input  logic                  dismiss,
    output logic [3:0]            sel_Mtens,
    output logic [3:0]            sel_Mones,
    output logic [3:0]            sel_Stens,
    output logic [3:0]            sel_Sones,
    output logic                  sel_ena,
    output logic [NUM_ALARMS-1:0] alarm_ena,
    output logic [NUM_ALARMS-1:0] snoozed,
    output logic                  ring,
    output logic [IDX_W-1:0]      ring_idx
);

    // Delaying the strobe lets the clock datapath advance before slots compare.
    logic tick_reg;

    always_ff @(posedge clk) begin
        if (rst) tick_reg <= 1'b0;
        else     tick_reg <= i_oneSecStrb;
    end

    logic [3:0]            slot_mtens [NUM_ALARMS];
    logic [3:0]            slot_mones [NUM_ALARMS];
    logic [3:0]            slot_stens [NUM_ALARMS];
    logic [3:0]            slot_sones [NUM_ALARMS];
    slot_state_t           slot_state [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] slot_ena;
    logic [NUM_ALARMS-1:0] ring_vec;

    generate
        for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_slot
            logic hit;
            logic match;

            // Only indices below NUM_ALARMS exist, so an out-of-range ld_sel hits nothing.
            assign hit   = (ld_sel == IDX_W'(gi));
            assign match = (slot_mtens[gi] == cur_Mtens) && (slot_mones[gi] == cur_Mones) &&
                           (slot_stens[gi] == cur_Stens) && (slot_sones[gi] == cur_Sones);

            alarm_slot #(
                .RING_SEC   (RING_SEC),
                .SNOOZE_SEC (SNOOZE_SEC),
                .CNT_W      (CNT_W)
            ) u_slot (
                .clk      (clk),
                .rst      (rst),
                .ld_mtens (hit & ld_Mtens),
                .ld_mones (hit & ld_Mones),
                .ld_stens (hit & ld_Stens),
                .ld_sones (hit & ld_Sones),
                .ld_num   (ld_num),
                .ena_set  (hit & ena_set),
                .ena_clr  (hit & ena_clr),
                .match    (match),
                .tick     (tick_reg),
                .snooze   (snooze),
                .dismiss  (dismiss),
                .mtens    (slot_mtens[gi]),
                .mones    (slot_mones[gi]),
                .stens    (slot_stens[gi]),
                .sones    (slot_sones[gi]),
                .ena      (slot_ena[gi]),
                .state    (slot_state[gi])
            );

            assign ring_vec[gi] = (slot_state[gi] == S_RING);
            assign snoozed[gi]  = (slot_state[gi] == S_SNOOZE);
        end
    endgenerate

    assign alarm_ena = slot_ena;
    assign ring      = |ring_vec;

    always_comb begin
        sel_Mtens = '0;
        sel_Mones = '0;
        sel_Stens = '0;
        sel_Sones = '0;
        sel_ena   = 1'b0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (ld_sel == IDX_W'(i)) begin
                sel_Mtens = slot_mtens[i];
                sel_Mones = slot_mones[i];
                sel_Stens = slot_stens[i];
                sel_Sones = slot_sones[i];
                sel_ena   = slot_ena[i];
            end
        end
    end

    always_comb begin
        ring_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (ring_vec[i]) ring_idx = IDX_W'(i);
        end
    end

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Directed bench for multi_alarm_ctrl with a per-cycle reference model and
// hand-computed checkpoints for latency, ring/snooze durations and priorities.
module tb_multi_alarm_ctrl;

    localparam int NA  = 4;
    localparam int IW  = 3;
    localparam int RS  = 30;
    localparam int SNZ = 60;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          strb = 1'b0;
    logic [3:0]    cur_Mtens = '0, cur_Mones = '0, cur_Stens = '0, cur_Sones = '0;
    logic [IW-1:0] ld_sel = '0;
    logic          ld_Mtens = 1'b0, ld_Mones = 1'b0, ld_Stens = 1'b0, ld_Sones = 1'b0;
    logic [3:0]    ld_num = '0;
    logic          ena_set = 1'b0, ena_clr = 1'b0, snooze = 1'b0, dismiss = 1'b0;
    logic [3:0]    sel_Mtens, sel_Mones, sel_Stens, sel_Sones;
    logic          sel_ena, ring;
    logic [NA-1:0] alarm_ena, snoozed;
    logic [IW-1:0] ring_idx;

    int n_vec = 0;
    int n_bad = 0;

    multi_alarm_ctrl #(
        .NUM_ALARMS (NA), .IDX_W (IW), .RING_SEC (RS), .SNOOZE_SEC (SNZ), .CNT_W (7)
    ) dut (
        .clk (clk), .rst (rst), .i_oneSecStrb (strb),
        .cur_Mtens (cur_Mtens), .cur_Mones (cur_Mones), .cur_Stens (cur_Stens), .cur_Sones (cur_Sones),
        .ld_sel (ld_sel), .ld_Mtens (ld_Mtens), .ld_Mones (ld_Mones), .ld_Stens (ld_Stens),
        .ld_Sones (ld_Sones), .ld_num (ld_num), .ena_set (ena_set), .ena_clr (ena_clr),
        .snooze (snooze), .dismiss (dismiss),
        .sel_Mtens (sel_Mtens), .sel_Mones (sel_Mones), .sel_Stens (sel_Stens), .sel_Sones (sel_Sones),
        .sel_ena (sel_ena), .alarm_ena (alarm_ena), .snoozed (snoozed), .ring (ring), .ring_idx (ring_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each slot is quiet, ringing or snoozed with seconds left.
    int  m_dig [NA][4];
    bit  m_ena [NA];
    bit  m_ring [NA];
    bit  m_snz [NA];
    int  m_left [NA];
    bit  m_tick = 1'b0;
    bit  armed = 1'b0;

    always @(posedge clk) begin : model
        bit hit, go_idle;
        if (rst) begin
            armed  <= 1'b1;
            m_tick <= 1'b0;
            for (int s = 0; s < NA; s++) begin
                for (int d = 0; d < 4; d++) m_dig[s][d] <= 0;
                m_ena[s] <= 1'b0; m_ring[s] <= 1'b0; m_snz[s] <= 1'b0; m_left[s] <= 0;
            end
        end else begin
            m_tick <= strb;
            for (int s = 0; s < NA; s++) begin
                hit     = (int'(ld_sel) == s);
                go_idle = dismiss || (hit && ena_clr);
                if (hit && ld_Mtens && ld_num <= 5) begin m_dig[s][0] <= int'(ld_num); go_idle = 1'b1; end
                if (hit && ld_Mones && ld_num <= 9) begin m_dig[s][1] <= int'(ld_num); go_idle = 1'b1; end
                if (hit && ld_Stens && ld_num <= 5) begin m_dig[s][2] <= int'(ld_num); go_idle = 1'b1; end
                if (hit && ld_Sones && ld_num <= 9) begin m_dig[s][3] <= int'(ld_num); go_idle = 1'b1; end
                if (hit && ena_clr)      m_ena[s] <= 1'b0;
                else if (hit && ena_set) m_ena[s] <= 1'b1;
                if (go_idle) begin
                    m_ring[s] <= 1'b0; m_snz[s] <= 1'b0; m_left[s] <= 0;
                end else if (snooze && m_ring[s]) begin
                    m_ring[s] <= 1'b0; m_snz[s] <= 1'b1; m_left[s] <= SNZ;
                end else if (m_tick) begin
                    if (m_ring[s] || m_snz[s]) begin
                        if (m_left[s] == 1) begin
                            m_ring[s] <= m_snz[s];
                            m_snz[s]  <= 1'b0;
                            m_left[s] <= m_snz[s] ? RS : 0;
                        end else begin
                            m_left[s] <= m_left[s] - 1;
                        end
                    end else if (m_ena[s] && m_dig[s][0] == int'(cur_Mtens) && m_dig[s][1] == int'(cur_Mones) &&
                                 m_dig[s][2] == int'(cur_Stens) && m_dig[s][3] == int'(cur_Sones)) begin
                        m_ring[s] <= 1'b1; m_left[s] <= RS;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        int e_ring, e_idx, e_snz, e_ena, e_sel, e_sel_ena, sidx;
        if (armed) begin
            e_ring = 0; e_idx = 0; e_snz = 0; e_ena = 0;
            for (int s = NA - 1; s >= 0; s--) begin
                if (m_ring[s]) begin e_ring = 1; e_idx = s; end
                if (m_snz[s]) e_snz |= (1 << s);
                if (m_ena[s]) e_ena |= (1 << s);
            end
            sidx = int'(ld_sel);
            e_sel = 0; e_sel_ena = 0;
            if (sidx < NA) begin
                e_sel = (m_dig[sidx][0] << 12) | (m_dig[sidx][1] << 8) | (m_dig[sidx][2] << 4) | m_dig[sidx][3];
                e_sel_ena = int'(m_ena[sidx]);
            end
            check("ring", int'(ring), e_ring);
            check("ring_idx", int'(ring_idx), e_idx);
            check("snoozed", int'(snoozed), e_snz);
            check("alarm_ena", int'(alarm_ena), e_ena);
            check("sel_time", int'({sel_Mtens, sel_Mones, sel_Stens, sel_Sones}), e_sel);
            check("sel_ena", int'(sel_ena), e_sel_ena);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_strobe();
        strb = 1'b1; cyc(); strb = 1'b0; cyc(); cyc();
    endtask

    task automatic set_cur(input int mt, input int mo, input int st, input int so);
        cur_Mtens = 4'(mt); cur_Mones = 4'(mo); cur_Stens = 4'(st); cur_Sones = 4'(so);
    endtask

    task automatic load_slot(input int s, input int mt, input int mo, input int st, input int so);
        ld_sel = IW'(s);
        ld_num = 4'(mt); ld_Mtens = 1'b1; cyc(); ld_Mtens = 1'b0;
        ld_num = 4'(mo); ld_Mones = 1'b1; cyc(); ld_Mones = 1'b0;
        ld_num = 4'(st); ld_Stens = 1'b1; cyc(); ld_Stens = 1'b0;
        ld_num = 4'(so); ld_Sones = 1'b1; cyc(); ld_Sones = 1'b0;
        ena_set = 1'b1; cyc(); ena_set = 1'b0;
        $display("load slot %0d = %0d%0d:%0d%0d, enabled", s, mt, mo, st, so);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int found;
        repeat (2) cyc();
        check("reset_ring", int'(ring), 0);
        check("reset_ena", int'(alarm_ena), 0);
        rst = 1'b0;
        cyc();
        $display("reset released");

        // Slot 2 at 01:30, two-cycle trigger latency
        load_slot(2, 0, 1, 3, 0);
        set_cur(0, 1, 3, 0);
        strb = 1'b1; cyc(); strb = 1'b0;
        check("lat_ring_early", int'(ring), 0);
        cyc();
        check("lat_ring", int'(ring), 1);
        check("lat_idx", int'(ring_idx), 2);
        check("lat_others", int'(snoozed), 0);
        $display("strobe at 01:30: ring=%0d ring_idx=%0d", ring, ring_idx);
        set_cur(0, 1, 3, 1);

        found = 0;
        for (int k = 1; k <= 40 && found == 0; k++) begin
            pulse_strobe();
            if (!ring) found = k;
        end
        check("ring_len", found, RS);
        $display("auto-silence after %0d ticks", found);

        // Retrigger, then snooze on the same cycle as a tick
        set_cur(0, 1, 3, 0);
        pulse_strobe();
        set_cur(0, 1, 3, 1);
        strb = 1'b1; cyc(); strb = 1'b0; snooze = 1'b1; cyc(); snooze = 1'b0;
        check("snz_ring", int'(ring), 0);
        check("snz_flag", int'(snoozed), 4'b0100);
        cyc();
        found = 0;
        for (int k = 1; k <= 70 && found == 0; k++) begin
            pulse_strobe();
            if (ring) found = k;
        end
        check("snooze_len", found, SNZ);
        check("snz_after", int'(snoozed), 0);
        $display("re-ring after %0d snoozed ticks", found);
        dismiss = 1'b1; cyc(); dismiss = 1'b0;
        check("dismiss_ring", int'(ring), 0);
        $display("dismiss slot 2");

        // Two slots matching the same tick
        load_slot(1, 0, 2, 0, 0);
        load_slot(3, 0, 2, 0, 0);
        set_cur(0, 2, 0, 0);
        pulse_strobe();
        check("multi_ring", int'(ring), 1);
        check("multi_idx", int'(ring_idx), 1);
        snooze = 1'b1; dismiss = 1'b1; cyc(); snooze = 1'b0; dismiss = 1'b0;
        check("sd_ring", int'(ring), 0);
        check("sd_snoozed", int'(snoozed), 0);
        strb = 1'b1; cyc(); strb = 1'b0; dismiss = 1'b1; cyc(); dismiss = 1'b0; cyc();
        check("dismiss_blocks_trigger", int'(ring), 0);
        $display("slots 1+3: priority, snooze+dismiss, dismiss on tick");
        set_cur(0, 3, 0, 0);

        // Range checks, enable priority, out-of-range select
        load_slot(0, 4, 5, 3, 8);
        ld_num = 4'd7; ld_Mtens = 1'b1; cyc(); ld_Mtens = 1'b0;
        ld_num = 4'd12; ld_Sones = 1'b1; cyc(); ld_Sones = 1'b0;
        check("bad_mtens", int'(sel_Mtens), 4);
        check("bad_sones", int'(sel_Sones), 8);
        ena_set = 1'b1; ena_clr = 1'b1; cyc(); ena_set = 1'b0; ena_clr = 1'b0;
        check("clr_over_set", int'(sel_ena), 0);
        ld_sel = 3'd5; ld_num = 4'd1; ld_Mtens = 1'b1; ena_set = 1'b1; cyc();
        ld_Mtens = 1'b0; ena_set = 1'b0;
        check("oor_sel", int'({sel_Mtens, sel_Mones, sel_Stens, sel_Sones}), 0);
        check("oor_ena", int'(alarm_ena), 4'b1110);
        $display("invalid loads and ld_sel=5 ignored");

        // Reset while slot 0 is snoozed
        ld_sel = 3'd0; ena_set = 1'b1; cyc(); ena_set = 1'b0;
        set_cur(4, 5, 3, 8);
        pulse_strobe();
        check("s0_idx", int'(ring_idx), 0);
        check("s0_ring", int'(ring), 1);
        snooze = 1'b1; cyc(); snooze = 1'b0;
        check("s0_snz", int'(snoozed), 4'b0001);
        rst = 1'b1; cyc(); rst = 1'b0;
        check("rst_ring", int'(ring), 0);
        check("rst_snz", int'(snoozed), 0);
        check("rst_ena", int'(alarm_ena), 0);
        check("rst_digits", int'({sel_Mtens, sel_Mones, sel_Stens, sel_Sones}), 0);
        $display("reset during snooze");
        repeat (3) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_alarm_ctrl.md
Name: multi_alarm_ctrl

Overview:
- Parametrised N-slot alarm controller for the MM:SS digital clock. It replaces the single fixed alarm with NUM_ALARMS independently loadable and enabled alarm slots.
- Each slot has a per-slot ring/snooze/auto-silence state machine, timed by the one-second strobe.
- It sits between the UART command decoder (load strobes, snooze/dismiss) and the display string and LED logic. It compares every slot against the running clock digits.

Parameters:
- NUM_ALARMS, 4, number of alarm slots (1..8)
- IDX_W, 2, slot index width; must be at least clog2(NUM_ALARMS), minimum 1
- RING_SEC, 30, seconds a slot rings before auto-silencing (1..127)
- SNOOZE_SEC, 60, snooze duration in seconds (1..127)
- CNT_W, 7, per-slot countdown width; must hold max(RING_SEC, SNOOZE_SEC)

Ports:
- clk  in  1  global clock (12 MHz)
- rst  in  1  reset, synchronous, active-high
- i_oneSecStrb  in  1  one-cycle strobe per second
- cur_Mtens, cur_Mones, cur_Stens, cur_Sones  in  4 each  current clock time, BCD
- ld_sel  in  IDX_W  slot addressed by the load, enable and display operations
- ld_Mtens, ld_Mones, ld_Stens, ld_Sones  in  1 each  digit load strobes
- ld_num  in  4  digit value to load
- ena_set, ena_clr  in  1 each  set or clear the enable of slot ld_sel
- snooze, dismiss  in  1 each  one-cycle user commands
- sel_Mtens, sel_Mones, sel_Stens, sel_Sones  out  4 each  stored time of slot ld_sel
- sel_ena  out  1  enable bit of slot ld_sel
- alarm_ena  out  NUM_ALARMS  per-slot enable bits
- snoozed  out  NUM_ALARMS  per-slot "in SNOOZED state"
- ring  out  1  any slot in RINGING
- ring_idx  out  IDX_W  lowest-index ringing slot; 0 when none is ringing

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): all slot digits 0, enables 0, states IDLE, counters 0, internal delayed strobe 0.
  - All registered outputs are 0 in the cycle after reset.
  - rst mid-ring or mid-snooze aborts immediately.
- Tick definition:
  - tick = i_oneSecStrb delayed by one register stage.
  - Match and countdown use tick, so the comparison sees the time after the clock datapath has incremented on the strobe.
- Loading:
  - A digit strobe writes ld_num into that digit of slot ld_sel at the next edge.
  - Range checks: Mtens and Stens loads with ld_num>5 are ignored; Mones and Sones loads with ld_num>9 are ignored.
  - Any ld_sel >= NUM_ALARMS makes all operations on that cycle no-ops, and sel_* read 0.
  - A successful digit load forces that slot to IDLE.
- Enable:
  - ena_clr has priority over ena_set.
  - Clearing the enable forces the slot to IDLE.
  - Setting the enable does not itself trigger a ring.
- Per-slot FSM, states IDLE, RINGING, SNOOZED (2-bit encoding):
  - IDLE -> RINGING on tick when enabled and all four digits equal cur_*. Counter loads RING_SEC.
  - RINGING: each tick decrements the counter. A tick with counter==1 -> IDLE (auto-silence).
  - RINGING -> SNOOZED on snooze. Counter loads SNOOZE_SEC.
  - SNOOZED: each tick decrements the counter. A tick with counter==1 -> RINGING, counter loads RING_SEC.
  - RINGING or SNOOZED -> IDLE on dismiss.
  - A match while RINGING or SNOOZED is ignored.
- Priority within a cycle, highest first: rst, load/ena_clr for the addressed slot, dismiss, snooze, tick.
  - dismiss also suppresses a new IDLE->RINGING trigger in the same cycle.
  - snooze coincident with tick: the counter takes SNOOZE_SEC and no decrement occurs.
- snooze and dismiss apply to all slots simultaneously.
- Latency:
  - ring rises 2 clk cycles after the matching i_oneSecStrb.
  - ring falls 1 cycle after dismiss or snooze.
- Output timing:
  - ring, snoozed and alarm_ena are decoded from registers.
  - ring_idx is a combinational priority encoder over the registered states.
  - sel_* and sel_ena are a combinational read of slot ld_sel.
- Counters never underflow. In IDLE the counter holds 0.

Decomposition:
- Shared package multi_alarm_pkg holds:
  - slot state encoding (S_IDLE=0, S_RING=1, S_SNOOZE=2)
  - BCD limits (TENS_MAX=5, ONES_MAX=9)
  - state width
- Sub-module alarm_slot: digits, enable, FSM and countdown for one slot. Inputs are its decoded load/enable strobes, a match flag, tick, snooze and dismiss.
- Top level: generate loop of NUM_ALARMS alarm_slot instances, plus the tick register, the ld_sel decode, the read mux and the priority encoder.

Test Plan:
- Load slot 2 = 01:30, ena_set, drive cur=01:30 and pulse strobe -> ring=1 and ring_idx=2 two cycles after the strobe; other slots stay IDLE.
- Slot 2 ringing with no input -> ring stays high for exactly 30 ticks, then falls (RING_SEC=30).
- Ringing slot 2, pulse snooze -> ring=0 and snoozed[2]=1; after 60 ticks ring=1 again and snoozed[2]=0.
- Slots 1 and 3 both match the same tick -> ring_idx=1; dismiss -> ring=0 and snoozed=0; snooze+dismiss in the same cycle -> dismiss wins.
- Load Mtens with ld_num=7, and Sones with ld_num=12 -> sel_Mtens and sel_Sones unchanged; ld_sel=5 with NUM_ALARMS=4 -> no state change and sel_*=0.
- rst asserted while slot 0 is SNOOZED -> next cycle all outputs 0, alarm_ena=0, slot digits 00:00.
